// File: rtl/apb_prio_intc.sv
// APB3 priority interrupt controller: per-source priority and threshold, plus a
// claim/complete handshake that allows a single interrupt in service at a time.
module apb_prio_intc #(
  parameter int NUM_IRQ = 8,
  parameter int PRIO_W  = 3,
  localparam int ID_W   = $clog2(NUM_IRQ + 1)
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o
);

  localparam logic [5:0] OFF_PEND   = 6'h00;
  localparam logic [5:0] OFF_CLEAR  = 6'h01;
  localparam logic [5:0] OFF_MASK   = 6'h02;
  localparam logic [5:0] OFF_MODE   = 6'h03;
  localparam logic [5:0] OFF_THRESH = 6'h04;
  localparam logic [5:0] OFF_CLAIM  = 6'h05;
  localparam logic [5:0] OFF_PRIO   = 6'h08;

  typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;

  state_t              state;
  logic [NUM_IRQ-1:0]  pending, mask, mode, prev;
  logic [PRIO_W-1:0]   thresh;
  logic [PRIO_W-1:0]   prio_q [NUM_IRQ];
  logic [ID_W-1:0]     in_service;

  logic [5:0]          off;
  logic                setup_rd, access, wr_ok, mapped, is_prio;
  logic                claim_go, complete;
  logic [ID_W-1:0]     wr_id, claim_id, best_id;
  logic [PRIO_W-1:0]   best_prio;
  logic [NUM_IRQ-1:0]  eligible, set_vec, clr_vec, pending_nxt;
  logic [31:0]         rd_val;
  logic                unused_bits;

  assign off         = paddr_i[7:2];
  assign setup_rd    = psel_i & ~penable_i & ~pwrite_i;
  assign access      = psel_i & penable_i;
  assign wr_id       = pwdata_i[ID_W-1:0];
  assign claim_id    = prdata_o[ID_W-1:0];
  assign pready_o    = 1'b1;
  assign unused_bits = ^{paddr_i[31:8], paddr_i[1:0], pwdata_i};

  always_comb begin
    is_prio = (off >= OFF_PRIO) && (off < 6'(8 + NUM_IRQ));
    mapped  = (off <= OFF_CLAIM) || is_prio;
  end

  assign pslverr_o = access & (~mapped
                             | (pwrite_i & (off == OFF_PEND))
                             | (pwrite_i & (off == OFF_CLAIM) & (wr_id != in_service)));
  assign wr_ok     = access & pwrite_i & ~pslverr_o;

  // A claim uses the ID captured at setup, so it completes even if that source
  // lost eligibility in between; a zero capture means the read began outside PEND.
  assign claim_go = access & ~pwrite_i & (off == OFF_CLAIM) & (state == PEND) & (claim_id != '0);
  assign complete = wr_ok & (off == OFF_CLAIM) & (state == SERVICE);

  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      eligible[k] = pending[k] & mask[k] & (prio_q[k] > thresh);
      if (eligible[k] && (prio_q[k] > best_prio)) begin
        best_prio = prio_q[k];
        best_id   = ID_W'(k + 1);
      end
    end
  end

  always_comb begin
    set_vec = (mode & irq_i & ~prev) | (~mode & irq_i);
    clr_vec = '0;
    if (wr_ok && (off == OFF_CLEAR)) clr_vec = pwdata_i[NUM_IRQ-1:0];
    for (int k = 0; k < NUM_IRQ; k++)
      if (claim_go && (claim_id == ID_W'(k + 1))) clr_vec[k] = 1'b1;
    pending_nxt = (pending & ~clr_vec) | set_vec;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_PEND:   rd_val[NUM_IRQ-1:0] = pending;
      OFF_MASK:   rd_val[NUM_IRQ-1:0] = mask;
      OFF_MODE:   rd_val[NUM_IRQ-1:0] = mode;
      OFF_THRESH: rd_val[PRIO_W-1:0]  = thresh;
      OFF_CLAIM:  if (state == PEND) rd_val[ID_W-1:0] = best_id;
      default:    ;
    endcase
    for (int k = 0; k < NUM_IRQ; k++)
      if (off == 6'(8 + k)) rd_val[PRIO_W-1:0] = prio_q[k];
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pending    <= '0;
      mask       <= '0;
      mode       <= '0;
      prev       <= '0;
      thresh     <= '0;
      in_service <= '0;
      prdata_o   <= '0;
      irq_o      <= 1'b0;
      irq_id_o   <= '0;
      for (int k = 0; k < NUM_IRQ; k++) prio_q[k] <= PRIO_W'(1);
    end else begin
      pending  <= pending_nxt;
      prev     <= irq_i;
      irq_id_o <= best_id;
      if (setup_rd) prdata_o <= rd_val;
      if (wr_ok) begin
        case (off)
          OFF_MASK:   mask   <= pwdata_i[NUM_IRQ-1:0];
          OFF_MODE:   mode   <= pwdata_i[NUM_IRQ-1:0];
          OFF_THRESH: thresh <= pwdata_i[PRIO_W-1:0];
          default:    ;
        endcase
        for (int k = 0; k < NUM_IRQ; k++)
          if (off == 6'(8 + k)) prio_q[k] <= pwdata_i[PRIO_W-1:0];
      end
      // No nesting: while in SERVICE nothing but a matching complete leaves.
      case (state)
        IDLE: begin
          if (best_id != '0) begin
            state <= PEND;
            irq_o <= 1'b1;
          end else begin
            irq_o <= 1'b0;
          end
        end
        PEND: begin
          if (claim_go) begin
            state      <= SERVICE;
            in_service <= claim_id;
            irq_o      <= 1'b0;
          end else if (best_id == '0) begin
            state <= IDLE;
            irq_o <= 1'b0;
          end else begin
            irq_o <= 1'b1;
          end
        end
        SERVICE: begin
          irq_o <= 1'b0;
          if (complete) begin
            state      <= IDLE;
            in_service <= '0;
          end
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_prio_intc.sv
// Bench for apb_prio_intc: directed scenarios followed by random APB traffic,
// all checked every cycle against a behavioural model of the controller.
module tb_apb_prio_intc;

  localparam int N   = 8;
  localparam int PW  = 3;
  localparam int IDW = 4;
  localparam int S_IDLE = 0, S_PEND = 1, S_SVC = 2;

  logic           pclk_i = 1'b0;
  logic           rst_i, psel_i, penable_i, pwrite_i;
  logic [31:0]    paddr_i, pwdata_i;
  logic [31:0]    prdata_o;
  logic           pready_o, pslverr_o, irq_o;
  logic [N-1:0]   irq_i;
  logic [IDW-1:0] irq_id_o;

  apb_prio_intc #(.NUM_IRQ(N), .PRIO_W(PW)) dut (
    .pclk_i(pclk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .irq_i(irq_i), .irq_o(irq_o), .irq_id_o(irq_id_o)
  );

  always #5 pclk_i = ~pclk_i;

  int nAssert = 0;
  int nFail   = 0;

  // Behavioural model state
  bit          mPend[N], mMask[N], mMode[N], mPrev[N];
  int          mPrio[N];
  int          mThresh, mState, mSvc, mId;
  logic [31:0] mPrdata;
  bit          mIrq;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelBest();
    int best = 0;
    int bp = 0;
    for (int k = 0; k < N; k++)
      if (mPend[k] && mMask[k] && mPrio[k] > mThresh && mPrio[k] > bp) begin
        bp = mPrio[k];
        best = k + 1;
      end
    return best;
  endfunction

  function automatic bit modelErr();
    int off;
    bit mapped;
    off = int'(paddr_i[7:2]);
    if (!(psel_i && penable_i)) return 1'b0;
    mapped = (off <= 5) || (off >= 8 && off < 8 + N);
    if (!mapped) return 1'b1;
    if (pwrite_i && off == 0) return 1'b1;
    if (pwrite_i && off == 5 && int'(pwdata_i[IDW-1:0]) != mSvc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelRead(input int off);
    logic [31:0] v = '0;
    case (off)
      0: for (int k = 0; k < N; k++) v[k] = mPend[k];
      2: for (int k = 0; k < N; k++) v[k] = mMask[k];
      3: for (int k = 0; k < N; k++) v[k] = mMode[k];
      4: v = 32'(mThresh);
      5: v = (mState == S_PEND) ? 32'(modelBest()) : 32'd0;
      default: if (off >= 8 && off < 8 + N) v = 32'(mPrio[off-8]);
    endcase
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelEdge();
    int off, best, claimId, nextState;
    bit acc, wr, claim, complete, setBit, clrBit;
    bit newPend[N];
    if (rst_i) begin
      for (int k = 0; k < N; k++) begin
        mPend[k] = 0; mMask[k] = 0; mMode[k] = 0; mPrev[k] = 0; mPrio[k] = 1;
      end
      mThresh = 0; mState = S_IDLE; mSvc = 0; mId = 0; mPrdata = '0; mIrq = 0;
      return;
    end
    off      = int'(paddr_i[7:2]);
    best     = modelBest();
    acc      = psel_i && penable_i;
    wr       = acc && pwrite_i && !modelErr();
    claimId  = int'(mPrdata[IDW-1:0]);
    claim    = acc && !pwrite_i && off == 5 && mState == S_PEND && claimId != 0;
    complete = wr && off == 5 && mState == S_SVC;
    for (int k = 0; k < N; k++) begin
      setBit = irq_i[k] && (!mMode[k] || !mPrev[k]);
      clrBit = (wr && off == 1 && pwdata_i[k]) || (claim && claimId == k + 1);
      newPend[k] = setBit || (mPend[k] && !clrBit);
    end
    if (psel_i && !penable_i && !pwrite_i) mPrdata = modelRead(off);
    nextState = mState;
    case (mState)
      S_IDLE: if (best != 0) nextState = S_PEND;
      S_PEND: begin
        if (claim) begin nextState = S_SVC; mSvc = claimId; end
        else if (best == 0) nextState = S_IDLE;
      end
      default: if (complete) begin nextState = S_IDLE; mSvc = 0; end
    endcase
    if (wr) begin
      case (off)
        2: for (int k = 0; k < N; k++) mMask[k] = pwdata_i[k];
        3: for (int k = 0; k < N; k++) mMode[k] = pwdata_i[k];
        4: mThresh = int'(pwdata_i[PW-1:0]);
        default: if (off >= 8 && off < 8 + N) mPrio[off-8] = int'(pwdata_i[PW-1:0]);
      endcase
    end
    mId    = best;
    mIrq   = (nextState == S_PEND);
    mState = nextState;
    for (int k = 0; k < N; k++) begin
      mPend[k] = newPend[k];
      mPrev[k] = irq_i[k];
    end
  endtask

  task automatic checkOutput();
    checkVal("irq_o", 32'(irq_o), 32'(mIrq));
    checkVal("irq_id_o", 32'(irq_id_o), 32'(mId));
    checkVal("prdata_o", prdata_o, mPrdata);
    checkVal("pready_o", 32'(pready_o), 32'd1);
    checkVal("pslverr_o", 32'(pslverr_o), 32'(modelErr()));
  endtask

  task automatic tick();
    modelEdge();
    @(posedge pclk_i);
    #1;
    checkOutput();
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data,
                          output bit err, input int accIrq);
    paddr_i = addr; pwdata_i = data; pwrite_i = 1; psel_i = 1; penable_i = 0;
    tick();
    penable_i = 1;
    if (accIrq >= 0) irq_i = N'(accIrq);
    #1;
    checkVal("pslverr_wr", 32'(pslverr_o), 32'(modelErr()));
    err = pslverr_o;
    tick();
    psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  task automatic apbRead(input logic [31:0] addr, output logic [31:0] data);
    paddr_i = addr; pwrite_i = 0; psel_i = 1; penable_i = 0;
    tick();
    penable_i = 1;
    #1;
    checkVal("pslverr_rd", 32'(pslverr_o), 32'(modelErr()));
    tick();
    data = prdata_o;
    psel_i = 0; penable_i = 0;
  endtask

  // One random APB operation with random source activity
  task automatic applyStimulus();
    int offList[18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 40};
    int off, r;
    logic [31:0] addr, d;
    bit e;
    irq_i = N'($urandom);
    off   = offList[$urandom_range(0, 17)];
    addr  = ($urandom & 32'hFFFF_FF00) | 32'(off << 2) | ($urandom & 32'h3);
    r     = $urandom_range(0, 9);
    case (r)
      0, 1: apbRead(32'h14, d);
      2:    apbWrite(32'h14, 32'(mSvc), e, -1);
      3:    apbWrite(32'h14, $urandom_range(0, 9), e, -1);
      4:    apbRead(addr, d);
      5, 6, 7, 8: apbWrite(addr, $urandom, e, -1);
      default: tick();
    endcase
  endtask

  logic [31:0] d;
  bit          e;

  initial begin
    rst_i = 1; psel_i = 0; penable_i = 0; pwrite_i = 0;
    paddr_i = '0; pwdata_i = '0; irq_i = '0;
    tick();
    tick();
    rst_i = 0;
    $display("[TB] reset values");
    checkVal("rst_irq_o", 32'(irq_o), 32'd0);
    for (int o = 0; o < 6; o++) begin
      apbRead(32'(o << 2), d);
      checkVal("rst_reg", d, 32'd0);
    end
    for (int k = 0; k < N; k++) begin
      apbRead(32'h20 + 32'(k << 2), d);
      checkVal("rst_prio", d, 32'd1);
    end

    $display("[TB] level-mode tie and claim");
    apbWrite(32'h08, 32'hFF, e, -1);
    apbWrite(32'h0C, 32'h00, e, -1);
    apbWrite(32'h28, 32'h5, e, -1);
    apbWrite(32'h38, 32'h5, e, -1);
    apbWrite(32'h10, 32'h2, e, -1);
    irq_i = 8'h44;
    tick();
    tick();
    checkVal("tie_irq_o", 32'(irq_o), 32'd1);
    checkVal("tie_id", 32'(irq_id_o), 32'd3);
    apbRead(32'h14, d);
    checkVal("claim_id3", d, 32'd3);
    checkVal("svc_irq_o", 32'(irq_o), 32'd0);

    $display("[TB] bad completes and unmapped access");
    apbWrite(32'h14, 32'd5, e, -1);
    checkVal("err_claim5", 32'(e), 32'd1);
    apbWrite(32'h18, 32'd0, e, -1);
    checkVal("err_unmapped", 32'(e), 32'd1);
    apbWrite(32'h00, 32'hFF, e, -1);
    checkVal("err_pend_wr", 32'(e), 32'd1);
    checkVal("still_svc", 32'(irq_o), 32'd0);
    apbWrite(32'h14, 32'd3, e, -1);
    checkVal("ok_complete3", 32'(e), 32'd0);

    $display("[TB] higher priority wins");
    apbWrite(32'h38, 32'h7, e, -1);
    tick();
    apbRead(32'h14, d);
    checkVal("claim_id7", d, 32'd7);
    irq_i = 8'h04;
    apbWrite(32'h04, 32'h40, e, -1);
    apbWrite(32'h14, 32'd7, e, -1);
    tick();
    tick();
    checkVal("after7_irq_o", 32'(irq_o), 32'd1);
    checkVal("after7_id", 32'(irq_id_o), 32'd3);
    irq_i = 8'h00;
    apbRead(32'h14, d);
    checkVal("claim_id3b", d, 32'd3);
    apbWrite(32'h14, 32'd3, e, -1);

    $display("[TB] edge mode");
    apbWrite(32'h0C, 32'h01, e, -1);
    apbWrite(32'h10, 32'h0, e, -1);
    irq_i = 8'h01;
    tick();
    irq_i = 8'h00;
    tick();
    checkVal("edge_irq_o", 32'(irq_o), 32'd1);
    apbRead(32'h00, d);
    checkVal("edge_pend", d, 32'h01);
    apbWrite(32'h04, 32'h01, e, -1);
    checkVal("clr_irq_o_hold", 32'(irq_o), 32'd1);
    tick();
    checkVal("clr_irq_o_low", 32'(irq_o), 32'd0);
    apbWrite(32'h04, 32'h01, e, 1);
    apbRead(32'h00, d);
    checkVal("set_beats_clr", d, 32'h01);
    irq_i = 8'h00;
    apbWrite(32'h04, 32'hFF, e, -1);

    $display("[TB] priority zero and reset in service");
    apbWrite(32'h0C, 32'h00, e, -1);
    apbWrite(32'h20, 32'h0, e, -1);
    apbWrite(32'h08, 32'h01, e, -1);
    irq_i = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal("prio0_quiet", 32'(irq_o), 32'd0);
    end
    apbWrite(32'h24, 32'h3, e, -1);
    apbWrite(32'h08, 32'h03, e, -1);
    irq_i = 8'h03;
    tick();
    tick();
    apbRead(32'h14, d);
    checkVal("claim_id2", d, 32'd2);
    paddr_i = 32'h14; pwdata_i = 32'd2; pwrite_i = 1; psel_i = 1; penable_i = 0;
    rst_i = 1;
    tick();
    checkVal("rst_svc_irq", 32'(irq_o), 32'd0);
    checkVal("rst_svc_id", 32'(irq_id_o), 32'd0);
    checkVal("rst_svc_prdata", prdata_o, 32'd0);
    rst_i = 0; psel_i = 0; pwrite_i = 0; irq_i = 8'h00;
    apbRead(32'h08, d);
    checkVal("rst_mask", d, 32'd0);
    apbRead(32'h24, d);
    checkVal("rst_prio1", d, 32'd1);

    $display("[TB] random traffic");
    apbWrite(32'h08, 32'hFF, e, -1);
    for (int i = 0; i < 300; i++) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
